// File: rtl/min_index_decoder.sv
`default_nettype none
// ============================================================================
// Module      : min_index_decoder
// Description : Decodes a 3-bit register index (0..5) captured under a
//               start strobe into a one-hot select of six registers R0..R5
//               and the selected register value. Indices 6 and 7 are
//               illegal: they raise error (held until ack) and bump a
//               saturating 8-bit counter.
//               Optional macro MIN_INDEX_DEC_CLAMP_EN: illegal indices are
//               clamped to 5 and take the valid path (error never asserts);
//               err_count still counts them.
// Ports       : clock     - system clock, rising edge
//               reset     - synchronous active-high reset
//               start     - request strobe, sampled only in IDLE
//               index     - register index, captured with start
//               regs      - packed R0..R5, R0 in the low WIDTH bits
//               ack       - consumer acknowledge of valid/error
//               busy      - high in every state except IDLE
//               valid     - sel/value valid, held until ack
//               sel       - one-hot register select
//               value     - selected register value (registered)
//               error     - illegal index captured, held until ack
//               done      - one-cycle pulse on acknowledged transaction
//               err_count - saturating illegal-request count
// Revision    : 1.0 - initial release
// ============================================================================
module min_index_decoder #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         index,
    input  logic [6*WIDTH-1:0] regs,
    input  logic               ack,
    output logic               busy,
    output logic               valid,
    output logic [5:0]         sel,
    output logic [WIDTH-1:0]   value,
    output logic               error,
    output logic               done,
    output logic [7:0]         err_count
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CHECK = 2'd1;
    localparam logic [1:0] c_VALID = 2'd2;
    localparam logic [1:0] c_ERROR = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [2:0]       r_idx;
    logic             r_valid;
    logic             r_error;
    logic             r_done;
    logic [5:0]       r_sel;
    logic [WIDTH-1:0] r_value;
    logic [7:0]       r_err_count;

    logic             w_illegal;
    logic             w_take_valid;
    logic [2:0]       w_idx_eff;
    logic [5:0]       w_sel_onehot;
    logic [WIDTH-1:0] w_slice;

    assign w_illegal = (r_idx > 3'd5);

`ifdef MIN_INDEX_DEC_CLAMP_EN
    // Out-of-range indices fold onto the top register.
    assign w_idx_eff    = w_illegal ? 3'd5 : r_idx;
    assign w_take_valid = 1'b1;
`else
    assign w_idx_eff    = r_idx;
    assign w_take_valid = !w_illegal;
`endif

    assign w_sel_onehot = 6'b000001 << w_idx_eff;

    // Explicit case keeps every slice in range even for indices 6/7.
    always_comb begin
        w_slice = regs[WIDTH-1:0];
        case (w_idx_eff)
            3'd1:    w_slice = regs[2*WIDTH-1:1*WIDTH];
            3'd2:    w_slice = regs[3*WIDTH-1:2*WIDTH];
            3'd3:    w_slice = regs[4*WIDTH-1:3*WIDTH];
            3'd4:    w_slice = regs[5*WIDTH-1:4*WIDTH];
            3'd5:    w_slice = regs[6*WIDTH-1:5*WIDTH];
            default: w_slice = regs[WIDTH-1:0];
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_CHECK;
            c_CHECK: w_next_state = w_take_valid ? c_VALID : c_ERROR;
            c_VALID: if (ack) w_next_state = c_IDLE;
            c_ERROR: if (ack) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_idx       <= 3'd0;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
            r_done      <= 1'b0;
            r_sel       <= 6'd0;
            r_value     <= '0;
            r_err_count <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_done  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) r_idx <= index;
                end
                c_CHECK: begin
                    if (w_take_valid) begin
                        r_sel   <= w_sel_onehot;
                        r_value <= w_slice;
                        r_valid <= 1'b1;
                    end else begin
                        r_sel   <= 6'd0;
                        r_error <= 1'b1;
                    end
                    if (w_illegal && (r_err_count != 8'hFF))
                        r_err_count <= r_err_count + 8'd1;
                end
                c_VALID: begin
                    if (ack) begin
                        r_valid <= 1'b0;
                        r_sel   <= 6'd0;
                        r_done  <= 1'b1;
                    end
                end
                c_ERROR: begin
                    if (ack) begin
                        r_error <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != c_IDLE);
    assign valid     = r_valid;
    assign error     = r_error;
    assign done      = r_done;
    assign sel       = r_sel;
    assign value     = r_value;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_min_index_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_min_index_decoder
// Description : Self-checking bench for min_index_decoder. Transactions are
//               driven with random register contents and compared against
//               expectations computed from a register array and a running
//               illegal-request count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_min_index_decoder;

    localparam int WIDTH = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [2:0]         index = 3'd0;
    logic [6*WIDTH-1:0] regs  = '0;
    logic               ack   = 1'b0;
    logic               busy;
    logic               valid;
    logic [5:0]         sel;
    logic [WIDTH-1:0]   value;
    logic               error;
    logic               done;
    logic [7:0]         err_count;

    min_index_decoder #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .index     (index),
        .regs      (regs),
        .ack       (ack),
        .busy      (busy),
        .valid     (valid),
        .sel       (sel),
        .value     (value),
        .error     (error),
        .done      (done),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic [WIDTH-1:0] m_regs [6];
    logic [WIDTH-1:0] m_value;
    int               m_err_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_regs_from_model();
        for (int k = 0; k < 6; k++) regs[k*WIDTH +: WIDTH] = m_regs[k];
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".busy"},  {31'd0, busy},  32'd0);
        check({tag, ".valid"}, {31'd0, valid}, 32'd0);
        check({tag, ".error"}, {31'd0, error}, 32'd0);
        check({tag, ".sel"},   {26'd0, sel},   32'd0);
        check({tag, ".value"}, {24'd0, value}, {24'd0, m_value});
        check({tag, ".errcnt"}, {24'd0, err_count}, m_err_count);
    endtask

    // Runs one transaction; entered and left at a negedge. ack_delay is the
    // number of hold cycles before ack; inject pulses a second start while
    // busy, which must be dropped.
    task automatic run_txn(input logic [2:0] idx, input int ack_delay, input bit inject);
        bit               legal_path;
        int               eff;
        logic [5:0]       exp_sel;
        start = 1'b1;
        index = idx;
        drive_regs_from_model();
        @(posedge clock);
        @(negedge clock);
        check("chk.busy",  {31'd0, busy},  32'd1);
        check("chk.valid", {31'd0, valid}, 32'd0);
        check("chk.error", {31'd0, error}, 32'd0);
        check("chk.done",  {31'd0, done},  32'd0);
        start = 1'b0;
        index = 3'($urandom);
        @(posedge clock);
        @(negedge clock);
        regs = {$urandom, $urandom};

`ifdef MIN_INDEX_DEC_CLAMP_EN
        legal_path = 1'b1;
        eff = (idx > 5) ? 5 : int'(idx);
`else
        legal_path = (idx <= 5);
        eff = int'(idx);
`endif
        if (idx > 5 && m_err_count < 255) m_err_count++;
        if (legal_path) begin
            exp_sel = 6'(1 << eff);
            m_value = m_regs[eff];
        end else begin
            exp_sel = 6'd0;
        end

        for (int c = 0; c <= ack_delay; c++) begin
            check("res.busy",   {31'd0, busy},  32'd1);
            check("res.valid",  {31'd0, valid}, {31'd0, legal_path});
            check("res.error",  {31'd0, error}, {31'd0, !legal_path});
            check("res.sel",    {26'd0, sel},   {26'd0, exp_sel});
            check("res.value",  {24'd0, value}, {24'd0, m_value});
            check("res.errcnt", {24'd0, err_count}, m_err_count);
            check("res.done",   {31'd0, done},  32'd0);
            if (c == ack_delay) break;
            start = inject && (c == 0);
            index = 3'd4;
            regs  = {$urandom, $urandom};
            @(posedge clock);
            @(negedge clock);
            start = 1'b0;
        end

        ack = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ack = 1'b0;
        check("ack.done", {31'd0, done}, 32'd1);
        check_idle_outputs("ack");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'($urandom);
        index = 3'($urandom);
        ack   = 1'($urandom);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        ack   = 1'b0;
        m_value = '0;
        m_err_count = 0;
        check("rst.done", {31'd0, done}, 32'd0);
        check_idle_outputs("rst");
    endtask

    initial begin
        @(negedge clock);
        do_reset();

        // Idle with ack toggling: nothing happens.
        for (int i = 0; i < 5; i++) begin
            ack = 1'($urandom);
            @(posedge clock);
            @(negedge clock);
            check("idle.done", {31'd0, done}, 32'd0);
            check_idle_outputs("idle");
        end
        ack = 1'b0;

        // Directed example: index 3, two hold cycles before ack.
        m_regs[0] = 8'h10; m_regs[1] = 8'h21; m_regs[2] = 8'h32;
        m_regs[3] = 8'h43; m_regs[4] = 8'h54; m_regs[5] = 8'h65;
        run_txn(3'd3, 2, 1'b0);
        @(posedge clock);
        @(negedge clock);
        check("post.done", {31'd0, done}, 32'd0);
        check_idle_outputs("post");

        // Back-to-back sweep, ack on first valid cycle.
        for (int i = 0; i < 6; i++) run_txn(3'(i), 0, 1'b0);

        // Illegal index with two hold cycles.
        run_txn(3'd7, 2, 1'b0);

        // Start while busy is dropped.
        run_txn(3'd2, 2, 1'b1);
        @(posedge clock);
        @(negedge clock);
        check("drop.done", {31'd0, done}, 32'd0);
        check_idle_outputs("drop");

        // Random transactions.
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 6; k++) m_regs[k] = WIDTH'($urandom);
            run_txn(3'($urandom_range(7, 0)), $urandom_range(3, 0), 1'($urandom));
        end

        // Reset while VALID: everything clears, no done pulse.
        start = 1'b1;
        index = 3'd1;
        drive_regs_from_model();
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("midrst.valid", {31'd0, valid}, 32'd1);
        do_reset();
        @(posedge clock);
        @(negedge clock);
        check("midrst.done", {31'd0, done}, 32'd0);
        check_idle_outputs("midrst");

        // Saturation of the illegal-request counter.
        for (int i = 0; i < 258; i++) begin
            for (int k = 0; k < 6; k++) m_regs[k] = WIDTH'($urandom);
            run_txn(3'($urandom_range(7, 6)), 0, 1'b0);
        end
        check("sat.errcnt", {24'd0, err_count}, 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
